gauss_skew_feeder: RTL



---
 rtl/gauss_skew_feeder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gauss_skew_feeder.sv
// -----------------------------------------------------------------------------
// gauss_skew_feeder
//
// Upstream feeder for a triangular Gaussian-elimination systolic array over
// GF(2). An M x N matrix is collected one row per handshake into a local row
// buffer. The buffer is then streamed column-wise with a diagonal skew into the
// top node of each array column: column j sees row i's bit j in stream cycle
// t = i + j.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   row_valid  row_data holds a valid matrix row
//   row_data   one matrix row, bit j = column j
//   row_ready  feeder can accept a row this cycle (LOAD state)
//   col_data   skewed bit into the top node of column j (data_in)
//   col_start  start strobe into the top node of column j (start_in)
//   busy       streaming in progress (STREAM state)
//   done       one-cycle pulse after the last skewed bit was issued
//
// Handshake: a row transfers on every rising edge where row_valid && row_ready
// are both high. The source holds row_valid/row_data stable until it sees the
// transfer. row_ready depends only on registered state, never on row_valid.
//
// Every output is decoded from registered state only. No combinational path
// exists from row_valid or row_data to any output.
// -----------------------------------------------------------------------------
module gauss_skew_feeder #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         row_valid,
  input  logic [N-1:0] row_data,
  output logic         row_ready,
  output logic [N-1:0] col_data,
  output logic [N-1:0] col_start,
  output logic         busy,
  output logic         done
);

  // Stream counter covers t = 0 .. M+N-2. It is cleared on every LOAD entry,
  // so it never wraps.
  localparam int TW = $clog2(M + N);
  // Row counter width. It is kept at least one bit wide so that M = 1 still
  // elaborates.
  localparam int RW = (M > 1) ? $clog2(M) : 1;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [N-1:0]  buffer_q [M];
  logic [N-1:0]  buffer_d [M];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    row_cnt_d = row_cnt_q;
    buffer_d  = buffer_q;
    case (state_q)
      ST_LOAD: begin
        if (row_valid) begin
          buffer_d[row_cnt_q] = row_data;
          if (row_cnt_q == RW'(M - 1)) begin
            row_cnt_d = '0;
            t_d       = '0;
            state_d   = ST_STREAM;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (t_q == TW'(M + N - 2)) begin
          t_d     = '0;
          state_d = ST_DONE;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_DONE: begin
        // The buffer is left alone. Rows are simply overwritten by the next job.
        t_d     = '0;
        state_d = ST_LOAD;
      end
      default: begin
        t_d       = '0;
        row_cnt_d = '0;
        state_d   = ST_LOAD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset wins over a simultaneous row_valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      t_q       <= '0;
      row_cnt_q <= '0;
      for (int i = 0; i < M; i++) begin
        buffer_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      row_cnt_q <= row_cnt_d;
      for (int i = 0; i < M; i++) begin
        buffer_q[i] <= buffer_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    row_ready = (state_q == ST_LOAD);
    busy      = (state_q == ST_STREAM);
    done      = (state_q == ST_DONE);
    col_data  = '0;
    col_start = '0;
    if (state_q == ST_STREAM) begin
      for (int j = 0; j < N; j++) begin
        // The start strobe lines up with row 0 reaching column j.
        col_start[j] = (t_q == TW'(j));
        // Diagonal skew: row i reaches column j at t = i + j. Outside the
        // window 0 <= t-j <= M-1, no row matches and the bit stays 0.
        for (int i = 0; i < M; i++) begin
          if (int'(t_q) == i + j) begin
            col_data[j] = buffer_q[i][j];
          end
        end
      end
    end
  end

endmodule
